csr_file: RTL
=============

Name: csr_file

Overview:
- Machine-mode CSR register file; sits directly downstream of the core-local interrupt arbiter.
- Accepts CSR accesses from two sources:
  - the execute stage, for CSR instructions;
  - the interrupt arbiter, for trap-entry and mret writes.
- Returns read data to both sources.
- Drives the arbiter's direct taps: mtvec, mepc, mstatus and the global interrupt enable.
- Maintains the free-running 64-bit cycle counter.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec.
- MSTATUS_RST, 32'h0000_0000, reset value of mstatus (MIE = bit 3).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ex_we_i  in  1  execute-stage CSR write enable
- ex_waddr_i  in  32  execute-stage write address (bits [11:0] decoded)
- ex_raddr_i  in  32  execute-stage read address
- ex_data_i  in  32  execute-stage write data
- ex_data_o  out  32  read data to execute stage
- int_we_i  in  1  interrupt-arbiter write enable
- int_waddr_i  in  32  interrupt-arbiter write address
- int_raddr_i  in  32  interrupt-arbiter read address
- int_data_i  in  32  interrupt-arbiter write data
- int_data_o  out  32  read data to interrupt arbiter
- csr_mtvec_o  out  32  mtvec register value
- csr_mepc_o  out  32  mepc register value
- csr_mstatus_o  out  32  mstatus register value
- global_int_en_o  out  1  equals mstatus[3]

Behaviour:
- Reset: clk, rst — synchronous, active-high.
  - mtvec = MTVEC_RST; mstatus = MSTATUS_RST.
  - mepc, mcause, mie, mscratch = 0.
  - cycle = 0.
- Outputs after reset:
  - ex_data_o and int_data_o reflect reset contents.
  - csr_mepc_o = 0; global_int_en_o = MSTATUS_RST[3].
- Implemented addresses, decode [11:0] only:
  - 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause.
  - 0xC00 cycle[31:0], 0xC80 cycle[63:32], both read-only.
  - 0xB00 mcycle[31:0], 0xB80 mcycle[63:32], both writable.
- Any other address: reads 0, writes dropped with no side effect.
- Writes:
  - Registered, taking effect at the next posedge.
  - One write per cycle.
  - If ex_we_i and int_we_i are both high, the ex write wins and the int write is dropped, including same-address conflicts. The arbiter's hold makes this a defensive case only.
- Reads: combinational, zero latency, two independent ports.
- Read forwarding: if a port's raddr matches the winning write address in the same cycle, that port returns the write data, not the stored value.
  - A dropped int write is never forwarded.
- Cycle counter: 64 bits, increments by 1 every cycle when not in reset.
  - Wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A write to 0xB00 replaces the low word and inhibits the increment that cycle; the high word is unchanged.
  - 0xB80 behaves the same for the high word.
  - The low-to-high carry is suppressed in a cycle where either half is written.
  - Reads of 0xC00/0xB00 return the current (pre-increment) value; forwarding applies to 0xB00/0xB80 only.
- Direct taps: csr_mtvec_o, csr_mepc_o, csr_mstatus_o and global_int_en_o are register values only, never forwarded. They update one cycle after the write.
- Reset mid-operation: a write presented in the reset cycle is discarded and all state returns to reset values.

Optional Feature:
- Macro: CSR_CYCLE_COUNTER_EN.
- Defined: 64-bit counter implemented as above.
- Undefined: no counter flops; 0xB00, 0xB80, 0xC00 and 0xC80 read 0 and writes are ignored, exactly like unimplemented addresses.

Test Plan:
- Reset, then read all addresses: mtvec = MTVEC_RST; mstatus = MSTATUS_RST; others 0; global_int_en_o = MSTATUS_RST[3]; cycle reads 0 in the first post-reset cycle and 1 in the next.
- Ex write 0x305 = 0x0000_0100: ex_data_o reads 0x100 the same cycle (forwarded); csr_mtvec_o = 0x100 from the next cycle.
- Int sequence mepc = 0x0000_2004, mstatus = 0x0000_0080, mcause = 0x8000_0004 on consecutive cycles: taps update one cycle after each write; global_int_en_o falls to 0 after the mstatus write.
- Simultaneous ex write 0x341 = 0xAAAA_AAAA and int write 0x341 = 0x5555_5555: mepc = 0xAAAA_AAAA; int_data_o reading 0x341 sees 0xAAAA_AAAA.
- Write 0xB00 = 0xFFFF_FFFF with high word 0: next cycle low word = 0xFFFF_FFFF and high = 0; following cycle low = 0 and high = 1. Write to 0xC00 is ignored.
- Build without CSR_CYCLE_COUNTER_EN: reads of 0xC00/0xB80 return 0 after 100 cycles; writes have no effect.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file, two read/write ports plus arbiter taps.
// Optional 64-bit cycle/mcycle counter enabled by CSR_CYCLE_COUNTER_EN.
module csr_file #(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_i,
  input  logic [31:0] ex_waddr_i,
  input  logic [31:0] ex_raddr_i,
  input  logic [31:0] ex_data_i,
  output logic [31:0] ex_data_o,
  input  logic        int_we_i,
  input  logic [31:0] int_waddr_i,
  input  logic [31:0] int_raddr_i,
  input  logic [31:0] int_data_i,
  output logic [31:0] int_data_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mstatus_o,
  output logic        global_int_en_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;

  logic [31:0] mstatus, mie, mtvec;
  logic [31:0] mscratch, mepc, mcause;

  logic        we;
  logic [11:0] wa;
  logic [31:0] wd;

  // ex has priority; a losing int write vanishes entirely
  always_comb begin
    we = ex_we_i | int_we_i;
    wa = ex_we_i ? ex_waddr_i[11:0] : int_waddr_i[11:0];
    wd = ex_we_i ? ex_data_i : int_data_i;
  end

`ifdef CSR_CYCLE_COUNTER_EN
  localparam logic [11:0] A_CYC_LO  = 12'hC00;
  localparam logic [11:0] A_CYC_HI  = 12'hC80;
  localparam logic [11:0] A_MCYC_LO = 12'hB00;
  localparam logic [11:0] A_MCYC_HI = 12'hB80;

  logic [31:0] cyc_lo, cyc_hi;
  logic        wr_lo, wr_hi;

  assign wr_lo = we && (wa == A_MCYC_LO);
  assign wr_hi = we && (wa == A_MCYC_HI);

  // a write to either half freezes the whole counter for that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_lo <= '0;
      cyc_hi <= '0;
    end else begin
      if (wr_lo)
        cyc_lo <= wd;
      else if (!wr_hi)
        cyc_lo <= cyc_lo + 32'd1;
      if (wr_hi)
        cyc_hi <= wd;
      else if (!wr_lo && (&cyc_lo))
        cyc_hi <= cyc_hi + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus  <= MSTATUS_RST;
      mie      <= '0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (we) begin
      case (wa)
        A_MSTATUS:  mstatus  <= wd;
        A_MIE:      mie      <= wd;
        A_MTVEC:    mtvec    <= wd;
        A_MSCRATCH: mscratch <= wd;
        A_MEPC:     mepc     <= wd;
        A_MCAUSE:   mcause   <= wd;
        default:    ;
      endcase
    end
  end

  function automatic logic [31:0] csr_rd(input logic [11:0] a);
    logic [31:0] r;
    case (a)
      A_MSTATUS:  r = mstatus;
      A_MIE:      r = mie;
      A_MTVEC:    r = mtvec;
      A_MSCRATCH: r = mscratch;
      A_MEPC:     r = mepc;
      A_MCAUSE:   r = mcause;
`ifdef CSR_CYCLE_COUNTER_EN
      A_CYC_LO, A_MCYC_LO: r = cyc_lo;
      A_CYC_HI, A_MCYC_HI: r = cyc_hi;
`endif
      default:    r = '0;
    endcase
    return r;
  endfunction

  // only addresses that actually store the write may forward it
  function automatic logic wr_ok(input logic [11:0] a);
    logic ok;
    ok = (a == A_MSTATUS) || (a == A_MIE) || (a == A_MTVEC) ||
         (a == A_MSCRATCH) || (a == A_MEPC) || (a == A_MCAUSE);
`ifdef CSR_CYCLE_COUNTER_EN
    ok = ok || (a == A_MCYC_LO) || (a == A_MCYC_HI);
`endif
    return ok;
  endfunction

  logic fwd_ok;
  assign fwd_ok = we && wr_ok(wa);

  always_comb begin
    ex_data_o = csr_rd(ex_raddr_i[11:0]);
    if (fwd_ok && (ex_raddr_i[11:0] == wa))
      ex_data_o = wd;
  end

  always_comb begin
    int_data_o = csr_rd(int_raddr_i[11:0]);
    if (fwd_ok && (int_raddr_i[11:0] == wa))
      int_data_o = wd;
  end

  assign csr_mtvec_o     = mtvec;
  assign csr_mepc_o      = mepc;
  assign csr_mstatus_o   = mstatus;
  assign global_int_en_o = mstatus[3];

  logic unused_hi;
  assign unused_hi = ^{ex_waddr_i[31:12], ex_raddr_i[31:12],
                       int_waddr_i[31:12], int_raddr_i[31:12]};

endmodule
